// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC bus arbiter slice.
//   arb_state_e           - transaction sequencer states
//   REQ_MICRO / REQ_POLL  - requester indices (KCPSM6 port path / time-refresh poller)
//   T_*_DEF               - default phase timings in clk cycles
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD,
        GAP
    } arb_state_e;

    localparam logic REQ_MICRO = 1'b0;
    localparam logic REQ_POLL  = 1'b1;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 3;
    localparam int T_HOLD_DEF  = 1;
    localparam int T_GAP_DEF   = 2;
    localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/rtc_bus_arbiter_phase_timer.sv
// rtc_phase_timer: loadable down-counter that times one sequencer state.
//   clk, reset (async, active-low)
//   load      - load load_val (a value of 0 is loaded as 1)
//   load_val  - state duration in cycles
//   last      - high during the final cycle of the loaded duration
module rtc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (cnt > CNT_W'(1)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the multiplexed RTC address/data bus between the
// KCPSM6 port path (requester 0) and the time-refresh poller (requester 1).
// Each transaction runs an address phase and a data phase on cs_n/ad/rd_n/wr_n.
//   req*/we*/addr*/wdata*  - per-requester request fields (sampled at grant)
//   gnt*/done*             - one-cycle grant / completion pulses
//   rdata                  - last read data, held until the next read completes
//   bus_din/bus_dout/bus_oe- pin-side data; the top level owns the tristate
//   cs_n/rd_n/wr_n/ad      - RTC strobes (ad: 0 address phase, 1 data phase)
//   busy                   - high whenever the sequencer is not idle
// Build option: RTC_ARB_FIXED_PRIO_EN gives requester 0 fixed priority
// instead of round-robin.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       done0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       done1,
    output logic [7:0] rdata,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP);

    arb_state_e       state;
    logic             owner;
    logic             we_q;
    logic [7:0]       wdata_q;
    logic             sel;
    logic             any_req;
    logic             tmr_load;
    logic             tmr_last;
    logic [CNT_W-1:0] phase_len;

`ifndef RTC_ARB_FIXED_PRIO_EN
    logic             rr_last;
`endif

    assign any_req = req0 | req1;

    always_comb begin
        sel = REQ_POLL;
`ifdef RTC_ARB_FIXED_PRIO_EN
        if (req0) sel = REQ_MICRO;
`else
        if (req0 && req1) sel = ~rr_last;
        else if (req0)    sel = REQ_MICRO;
`endif
    end

    // The timer is loaded with the duration of the state being entered,
    // so phase_len is keyed on the state being left.
    always_comb begin
        phase_len = LD_SETUP;
        case (state)
            IDLE:    phase_len = LD_SETUP;
            A_SET:   phase_len = LD_PULSE;
            A_STB:   phase_len = LD_HOLD;
            A_HLD:   phase_len = LD_SETUP;
            D_SET:   phase_len = LD_PULSE;
            D_STB:   phase_len = LD_HOLD;
            D_HLD:   phase_len = LD_GAP;
            default: phase_len = LD_SETUP;
        endcase
    end

    assign tmr_load = (state == IDLE) ? any_req : tmr_last;

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (phase_len),
        .last     (tmr_last)
    );

    // Outputs are set on the edge that enters each state so that every
    // strobe is a plain register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            ad       <= 1'b0;
            bus_oe   <= 1'b0;
            bus_dout <= '0;
            rdata    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            owner    <= REQ_MICRO;
            we_q     <= 1'b0;
            wdata_q  <= '0;
`ifndef RTC_ARB_FIXED_PRIO_EN
            rr_last  <= REQ_POLL;
`endif
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= sel;
                        we_q     <= sel ? we1 : we0;
                        wdata_q  <= sel ? wdata1 : wdata0;
                        gnt0     <= (sel == REQ_MICRO);
                        gnt1     <= (sel == REQ_POLL);
`ifndef RTC_ARB_FIXED_PRIO_EN
                        rr_last  <= sel;
`endif
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        ad       <= 1'b0;
                        bus_oe   <= 1'b1;
                        bus_dout <= sel ? addr1 : addr0;
                        state    <= A_SET;
                    end
                end
                A_SET: begin
                    if (tmr_last) begin
                        wr_n  <= 1'b0;
                        state <= A_STB;
                    end
                end
                A_STB: begin
                    if (tmr_last) begin
                        wr_n  <= 1'b1;
                        state <= A_HLD;
                    end
                end
                A_HLD: begin
                    if (tmr_last) begin
                        ad <= 1'b1;
                        if (we_q) begin
                            bus_dout <= wdata_q;
                            bus_oe   <= 1'b1;
                        end else begin
                            bus_oe   <= 1'b0;
                        end
                        state <= D_SET;
                    end
                end
                D_SET: begin
                    if (tmr_last) begin
                        if (we_q) wr_n <= 1'b0;
                        else      rd_n <= 1'b0;
                        state <= D_STB;
                    end
                end
                D_STB: begin
                    if (tmr_last) begin
                        if (!we_q) rdata <= bus_din;
                        wr_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        state <= D_HLD;
                    end
                end
                D_HLD: begin
                    if (tmr_last) begin
                        cs_n   <= 1'b1;
                        ad     <= 1'b0;
                        bus_oe <= 1'b0;
                        done0  <= (owner == REQ_MICRO);
                        done1  <= (owner == REQ_POLL);
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (tmr_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
module tb_rtc_bus_arbiter;

    localparam int S    = 2;
    localparam int P    = 3;
    localparam int H    = 1;
    localparam int G    = 2;
    localparam int HALF = S + P + H;
    localparam int N    = 2 * HALF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1, bus_din;
    logic       gnt0, done0, gnt1, done1, bus_oe, cs_n, rd_n, wr_n, ad, busy;
    logic [7:0] rdata, bus_dout;

    logic       e_req0;
    logic       e_gnt0, e_done0, e_gnt1, e_done1, e_bus_oe, e_cs_n, e_rd_n, e_wr_n, e_ad, e_busy;
    logic [7:0] e_rdata, e_bus_dout;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    rtc_bus_arbiter #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_GAP(G), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad(ad), .busy(busy)
    );

    rtc_bus_arbiter #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(0), .T_GAP(0), .CNT_W(4)) dut_e (
        .clk(clk), .reset(reset),
        .req0(e_req0), .we0(1'b1), .addr0(8'h7E), .wdata0(8'h3C), .gnt0(e_gnt0), .done0(e_done0),
        .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00), .gnt1(e_gnt1), .done1(e_done1),
        .rdata(e_rdata), .bus_din(bus_din), .bus_dout(e_bus_dout), .bus_oe(e_bus_oe),
        .cs_n(e_cs_n), .rd_n(e_rd_n), .wr_n(e_wr_n), .ad(e_ad), .busy(e_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transaction is a timeline of cycles k=1..
    // after its grant edge; every output follows from where k falls.
    bit         m_act;
    int         m_k;
    logic       m_own, m_we, m_rr;
    logic [7:0] m_addr, m_wdata, m_rdata;

    function automatic logic pick(input logic r0, input logic r1, input logic rr);
`ifdef RTC_ARB_FIXED_PRIO_EN
        if (r0) return 1'b0;
        return (rr & 1'b0) | 1'b1;
`else
        if (r0 && r1) return ~rr;
        return r0 ? 1'b0 : 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act   <= 1'b0;
            m_k     <= 0;
            m_rr    <= 1'b1;
            m_rdata <= 8'h00;
        end else if (!m_act) begin
            if (req0 || req1) begin
                m_act   <= 1'b1;
                m_k     <= 1;
                m_own   <= pick(req0, req1, m_rr);
                m_rr    <= pick(req0, req1, m_rr);
                m_we    <= pick(req0, req1, m_rr) ? we1 : we0;
                m_addr  <= pick(req0, req1, m_rr) ? addr1 : addr0;
                m_wdata <= pick(req0, req1, m_rr) ? wdata1 : wdata0;
            end
        end else begin
            if (!m_we && m_k == HALF + S + P) m_rdata <= bus_din;
            if (m_k == N + G) m_act <= 1'b0;
            else              m_k   <= m_k + 1;
        end
    end

    bit x_cs, x_astb, x_dstb, x_oe;

    always @(negedge clk) begin
        if (reset === 1'b1 && cmp_en) begin
            x_cs   = m_act && m_k <= N;
            x_astb = m_act && m_k >= S + 1 && m_k <= S + P;
            x_dstb = m_act && m_k >= HALF + S + 1 && m_k <= HALF + S + P;
            x_oe   = m_act && (m_k <= HALF || (m_k <= N && m_we));
            chk("cs_n",  cs_n,  !x_cs);
            chk("wr_n",  wr_n,  !(x_astb || (x_dstb && m_we)));
            chk("rd_n",  rd_n,  !(x_dstb && !m_we));
            chk("ad",    ad,    m_act && m_k > HALF && m_k <= N);
            chk("bus_oe", bus_oe, x_oe);
            if (x_oe) chk("bus_dout", bus_dout, (m_k <= HALF) ? m_addr : m_wdata);
            chk("gnt0",  gnt0,  m_act && m_k == 1 && m_own == 1'b0);
            chk("gnt1",  gnt1,  m_act && m_k == 1 && m_own == 1'b1);
            chk("done0", done0, m_act && m_k == N + 1 && m_own == 1'b0);
            chk("done1", done1, m_act && m_k == N + 1 && m_own == 1'b1);
            chk("busy",  busy,  m_act);
            chk("rdata", rdata, m_rdata);
        end
    end

    // Per-cycle trace of one transaction, k=1 is the grant cycle.
    logic       tr_cs[1:32], tr_wr[1:32], tr_rd[1:32], tr_oe[1:32], tr_done[1:32];
    logic [7:0] tr_dout[1:32];

    task automatic trace(input int n, input bit use_e);
        for (int k = 1; k <= n; k++) begin
            tr_cs[k]   = use_e ? e_cs_n : cs_n;
            tr_wr[k]   = use_e ? e_wr_n : wr_n;
            tr_rd[k]   = use_e ? e_rd_n : rd_n;
            tr_oe[k]   = use_e ? e_bus_oe : bus_oe;
            tr_dout[k] = use_e ? e_bus_dout : bus_dout;
            tr_done[k] = use_e ? (e_done0 | e_done1) : (done0 | done1);
            if (k < n) @(negedge clk);
        end
    endtask

    task automatic summarize(input int n, output int cs_low, output int wr_low,
                             output int rd_low, output int done_k, output int oe_rd);
        cs_low = 0; wr_low = 0; rd_low = 0; done_k = 0; oe_rd = 0;
        for (int k = 1; k <= n; k++) begin
            if (!tr_cs[k]) cs_low++;
            if (!tr_wr[k]) wr_low++;
            if (!tr_rd[k]) begin
                rd_low++;
                if (tr_oe[k]) oe_rd++;
            end
            if (tr_done[k] && done_k == 0) done_k = k;
        end
    endtask

    task automatic wait_gnt(input bit use_e, output int who, output int nc);
        who = -1;
        nc  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((use_e ? e_gnt0 : gnt0) === 1'b1) begin who = 0; nc = i; break; end
            if ((use_e ? e_gnt1 : gnt1) === 1'b1) begin who = 1; nc = i; break; end
        end
        if (who < 0) chk("gnt_timeout", 1, 0);
    endtask

    int who, nc, cs_low, wr_low, rd_low, done_k, oe_rd, cnt;
    int ord[4], gap[4];
`ifdef RTC_ARB_FIXED_PRIO_EN
    int exp_ord[4] = '{0, 0, 0, 0};
`else
    int exp_ord[4] = '{0, 1, 0, 1};
`endif

    initial begin
        reset = 1'b0; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; bus_din = 0; e_req0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);     chk("rst_rd_n", rd_n, 1);
        chk("rst_wr_n", wr_n, 1);     chk("rst_ad", ad, 0);
        chk("rst_oe", bus_oe, 0);     chk("rst_dout", bus_dout, 0);
        chk("rst_rdata", rdata, 0);   chk("rst_busy", busy, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1}, 4'b0000);
        reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // micro write
        we0 = 1; addr0 = 8'h21; wdata0 = 8'h45; req0 = 1;
        wait_gnt(0, who, nc); req0 = 0;
        chk("wr_owner", who, 0);
        trace(20, 0); summarize(20, cs_low, wr_low, rd_low, done_k, oe_rd);
        chk("wr_cs_low", cs_low, 12);    chk("wr_wr_low", wr_low, 6);
        chk("wr_rd_low", rd_low, 0);     chk("wr_done_k", done_k, 13);
        chk("wr_astb", {tr_wr[3], tr_dout[3]}, {1'b0, 8'h21});
        chk("wr_dstb", {tr_wr[9], tr_dout[9]}, {1'b0, 8'h45});

        // poller read
        bus_din = 8'h59; we1 = 0; addr1 = 8'h24; req1 = 1;
        wait_gnt(0, who, nc); req1 = 0;
        chk("rd_owner", who, 1);
        trace(20, 0); summarize(20, cs_low, wr_low, rd_low, done_k, oe_rd);
        chk("rd_rd_low", rd_low, 3);     chk("rd_oe_during_rd", oe_rd, 0);
        chk("rd_wr_low", wr_low, 3);     chk("rd_done_k", done_k, 13);
        chk("rd_cs_low", cs_low, 12);    chk("rd_rdata", rdata, 8'h59);
        bus_din = 8'hA5;

        // contention, both held
        we0 = 1; addr0 = 8'h31; wdata0 = 8'h11; we1 = 0; addr1 = 8'h32;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(0, who, nc);
            ord[i] = who; gap[i] = nc;
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 4; i++) chk("cont_order", ord[i], exp_ord[i]);
        for (int i = 1; i < 4; i++) chk("cont_spacing", gap[i], N + G + 1);
        repeat (20) @(negedge clk);
        chk("cont_idle", busy, 0);

        // req1 pulsed and withdrawn during a req0 transaction
        we0 = 1; addr0 = 8'h40; wdata0 = 8'h41; req0 = 1;
        wait_gnt(0, who, nc); req0 = 0;
        repeat (3) @(negedge clk);
        req1 = 1; @(negedge clk); req1 = 0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt1) cnt++;
        end
        chk("wd_no_gnt1", cnt, 0);
        chk("wd_idle", busy, 0);

        // reset during data strobe of a read
        we0 = 0; addr0 = 8'h50; req0 = 1;
        wait_gnt(0, who, nc); req0 = 0;
        repeat (9) @(negedge clk);
        chk("mid_in_dstb", rd_n, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_cs_n", cs_n, 1);  chk("mid_rd_n", rd_n, 1);
        chk("mid_wr_n", wr_n, 1);  chk("mid_oe", bus_oe, 0);
        chk("mid_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0 || done1) cnt++;
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done0 || done1) cnt++;
        end
        chk("mid_no_done", cnt, 0);
        we0 = 1; addr0 = 8'h60; wdata0 = 8'h61; req0 = 1;
        wait_gnt(0, who, nc); req0 = 0;
        chk("post_owner", who, 0);
        trace(20, 0); summarize(20, cs_low, wr_low, rd_low, done_k, oe_rd);
        chk("post_done_k", done_k, 13); chk("post_cs_low", cs_low, 12);

        // minimum timing instance
        e_req0 = 1;
        wait_gnt(1, who, nc); e_req0 = 0;
        chk("edge_owner", who, 0);
        trace(10, 1); summarize(10, cs_low, wr_low, rd_low, done_k, oe_rd);
        chk("edge_cs_low", cs_low, 6);  chk("edge_wr_low", wr_low, 2);
        chk("edge_done_k", done_k, 7);  chk("edge_rd_low", rd_low, 0);
        chk("edge_idle", {e_busy, e_ad, e_rdata}, 10'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
